// File: rtl/hazard_scoreboard_if.sv
// D-stage hazard bundle between the decoder and hazard_scoreboard.
// Master drives the decoded D fields, slave returns stall/forward.
interface hazard_scoreboard_if #(
  parameter int AW = 5,
  parameter int TW = 2,
  parameter int SW = 2
);
  logic          en;
  logic [AW-1:0] a1_d;
  logic [AW-1:0] a2_d;
  logic [AW-1:0] a3_d;
  logic          we_d;
  logic [TW-1:0] tnew_d;
  logic          use_rs_d;
  logic          use_rt_d;
  logic [TW-1:0] tuse_rs_d;
  logic [TW-1:0] tuse_rt_d;
  logic          flush_e;
  logic          stall;
  logic [SW-1:0] fwd_rs_sel;
  logic [SW-1:0] fwd_rt_sel;
  logic [31:0]   stall_cnt;

  modport master (
    output en, a1_d, a2_d, a3_d, we_d, tnew_d,
    output use_rs_d, use_rt_d, tuse_rs_d, tuse_rt_d,
    output flush_e,
    input  stall, fwd_rs_sel, fwd_rt_sel, stall_cnt
  );

  modport slave (
    input  en, a1_d, a2_d, a3_d, we_d, tnew_d,
    input  use_rs_d, use_rt_d, tuse_rs_d, tuse_rt_d,
    input  flush_e,
    output stall, fwd_rs_sel, fwd_rt_sel, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Shift-register scoreboard of in-flight writers (E..W) producing
// the D-stage stall request, rs/rt forward selects and a stall counter.
module hazard_scoreboard #(
  parameter int DEPTH = 3,
  parameter int TW    = 2,
  parameter int AW    = 5,
  parameter int SW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  hazard_scoreboard_if.slave bus
);

  logic          r_v    [DEPTH];
  logic [AW-1:0] r_a3   [DEPTH];
  logic [TW-1:0] r_tnew [DEPTH];
  logic [31:0]   r_cnt;

  logic          w_rs_hit;
  logic [SW-1:0] w_rs_sel;
  logic [TW-1:0] w_rs_tn;
  logic          w_rt_hit;
  logic [SW-1:0] w_rt_sel;
  logic [TW-1:0] w_rt_tn;
  logic          w_stall;
  logic          w_kill;

  // Scan oldest to youngest so the youngest match overwrites the rest.
  always_comb begin
    w_rs_hit = 1'b0;
    w_rs_sel = '0;
    w_rs_tn  = '0;
    w_rt_hit = 1'b0;
    w_rt_sel = '0;
    w_rt_tn  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (bus.use_rs_d && r_v[i] && r_a3[i] != '0 &&
          r_a3[i] == bus.a1_d) begin
        w_rs_hit = 1'b1;
        w_rs_sel = SW'(i + 1);
        w_rs_tn  = r_tnew[i];
      end
      if (bus.use_rt_d && r_v[i] && r_a3[i] != '0 &&
          r_a3[i] == bus.a2_d) begin
        w_rt_hit = 1'b1;
        w_rt_sel = SW'(i + 1);
        w_rt_tn  = r_tnew[i];
      end
    end
  end

  assign w_stall = (w_rs_hit && w_rs_tn > bus.tuse_rs_d) ||
                   (w_rt_hit && w_rt_tn > bus.tuse_rt_d);
  assign w_kill  = w_stall || bus.flush_e || !bus.we_d;

  assign bus.stall      = w_stall;
  assign bus.fwd_rs_sel = (w_rs_hit && w_rs_tn == '0) ? w_rs_sel : '0;
  assign bus.fwd_rt_sel = (w_rt_hit && w_rt_tn == '0) ? w_rt_sel : '0;
  assign bus.stall_cnt  = r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_v[i]    <= 1'b0;
        r_a3[i]   <= '0;
        r_tnew[i] <= '0;
      end
      r_cnt <= '0;
    end else if (bus.en) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        r_v[i]    <= r_v[i-1];
        r_a3[i]   <= r_a3[i-1];
        r_tnew[i] <= (r_tnew[i-1] == '0) ? '0 : r_tnew[i-1] - TW'(1);
      end
      r_v[0]    <= !w_kill;
      r_a3[0]   <= w_kill ? '0 : bus.a3_d;
      r_tnew[0] <= w_kill ? '0 : bus.tnew_d;
      if (w_stall && r_cnt != 32'hFFFF_FFFF)
        r_cnt <= r_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, async reset
// sequence, then random stimulus against a queue-based reference model.
module tb_hazard_scoreboard;
  localparam int DEPTH = 3;
  localparam int TW    = 2;
  localparam int AW    = 5;
  localparam int SW    = 2;

  typedef struct {
    int a1; int a2; int a3; bit we; int tn;
    bit urs; bit urt; int trs; int trt; bit fl; bit en;
    bit es; int ers; int ert; int ecnt;
  } vec_t;

  typedef struct { bit v; int a3; int tn; } ent_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  ent_t mq[$];
  int   mcnt;
  vec_t tv[32];

  hazard_scoreboard_if #(.AW(AW), .TW(TW), .SW(SW)) bus ();

  hazard_scoreboard #(.DEPTH(DEPTH), .TW(TW), .AW(AW), .SW(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t nop(input int c);
    vec_t x;
    x = '{0,0,0,0,0,0,0,0,0,0,1, 0,0,0,c};
    return x;
  endfunction

  task automatic drive(input vec_t x);
    bus.a1_d      = AW'(x.a1);
    bus.a2_d      = AW'(x.a2);
    bus.a3_d      = AW'(x.a3);
    bus.we_d      = x.we;
    bus.tnew_d    = TW'(x.tn);
    bus.use_rs_d  = x.urs;
    bus.use_rt_d  = x.urt;
    bus.tuse_rs_d = TW'(x.trs);
    bus.tuse_rt_d = TW'(x.trt);
    bus.flush_e   = x.fl;
    bus.en        = x.en;
  endtask

  function automatic void m_reset();
    ent_t e;
    e = '{0, 0, 0};
    mq.delete();
    for (int i = 0; i < DEPTH; i++) mq.push_back(e);
    mcnt = 0;
  endfunction

  // First queue hit is the youngest writer; only it decides.
  function automatic void m_eval(input vec_t x, output bit st,
                                 output int rs, output int rt);
    bit frs, frt;
    st = 0; rs = 0; rt = 0; frs = 0; frt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!frs && x.urs && mq[i].v && mq[i].a3 != 0 && mq[i].a3 == x.a1) begin
        frs = 1;
        if (mq[i].tn > x.trs) st = 1;
        if (mq[i].tn == 0) rs = i + 1;
      end
      if (!frt && x.urt && mq[i].v && mq[i].a3 != 0 && mq[i].a3 == x.a2) begin
        frt = 1;
        if (mq[i].tn > x.trt) st = 1;
        if (mq[i].tn == 0) rt = i + 1;
      end
    end
  endfunction

  function automatic void m_step(input vec_t x);
    bit st; int rs, rt;
    ent_t e;
    if (!x.en) return;
    m_eval(x, st, rs, rt);
    if (st && mcnt != 32'hFFFF_FFFF) mcnt++;
    for (int i = 0; i < DEPTH; i++)
      if (mq[i].tn > 0) mq[i].tn--;
    void'(mq.pop_back());
    if (st || x.fl || !x.we) e = '{0, 0, 0};
    else e = '{1, x.a3, x.tn};
    mq.push_front(e);
  endfunction

  initial begin
    vec_t x;
    bit   st;
    int   rs, rt;
    checks = 0;
    errors = 0;

    tv[0]  = '{0,0,8,1,2,0,0,0,0,0,1, 0,0,0,0};
    tv[1]  = '{8,0,9,1,1,1,0,1,0,0,1, 1,0,0,0};
    tv[2]  = '{8,0,9,1,1,1,0,1,0,0,1, 0,0,0,1};
    tv[3]  = nop(1);
    tv[4]  = nop(1);
    tv[5]  = nop(1);
    tv[6]  = '{0,0,8,1,2,0,0,0,0,0,1, 0,0,0,1};
    tv[7]  = '{8,8,0,0,0,1,1,0,0,0,1, 1,0,0,1};
    tv[8]  = '{8,8,0,0,0,1,1,0,0,0,1, 1,0,0,2};
    tv[9]  = '{8,8,0,0,0,1,1,0,0,0,1, 0,3,3,3};
    tv[10] = '{0,0,5,1,1,0,0,0,0,0,1, 0,0,0,3};
    tv[11] = '{29,5,0,0,0,1,1,1,2,0,1, 0,0,0,3};
    tv[12] = '{29,5,0,0,0,1,1,1,2,0,1, 0,0,2,3};
    tv[13] = nop(3);
    tv[14] = '{0,0,0,1,2,0,0,0,0,0,1, 0,0,0,3};
    tv[15] = '{0,0,0,0,0,1,1,0,0,0,1, 0,0,0,3};
    tv[16] = nop(3);
    tv[17] = nop(3);
    tv[18] = '{0,0,7,1,0,0,0,0,0,0,1, 0,0,0,3};
    tv[19] = '{0,0,7,1,2,0,0,0,0,0,1, 0,0,0,3};
    tv[20] = '{7,0,0,0,0,1,0,1,0,0,1, 1,0,0,3};
    tv[21] = '{7,0,0,0,0,1,0,1,0,0,1, 0,0,0,4};
    tv[22] = nop(4);
    tv[23] = '{0,0,8,1,2,0,0,0,0,0,1, 0,0,0,4};
    tv[24] = '{8,8,0,0,0,1,1,0,0,0,0, 1,0,0,4};
    tv[25] = '{8,8,0,0,0,1,1,0,0,0,0, 1,0,0,4};
    tv[26] = '{8,8,0,0,0,1,1,0,0,0,0, 1,0,0,4};
    tv[27] = '{8,8,0,0,0,1,1,0,0,0,1, 1,0,0,4};
    tv[28] = '{8,8,0,0,0,1,1,0,0,0,1, 1,0,0,5};
    tv[29] = '{8,8,0,0,0,1,1,0,0,0,1, 0,3,3,6};
    tv[30] = '{0,0,10,1,2,0,0,0,0,1,1, 0,0,0,6};
    tv[31] = '{10,0,0,0,0,1,0,0,0,0,1, 0,0,0,6};

    reset = 1'b0;
    drive(nop(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'd0, bus.stall}, 0);
    chk("rst_cnt", bus.stall_cnt, 0);
    reset = 1'b1;

    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      drive(tv[i]);
      #1;
      chk($sformatf("v%0d_stall", i), {31'd0, bus.stall}, tv[i].es);
      chk($sformatf("v%0d_rs", i), {30'd0, bus.fwd_rs_sel}, tv[i].ers);
      chk($sformatf("v%0d_rt", i), {30'd0, bus.fwd_rt_sel}, tv[i].ert);
      chk($sformatf("v%0d_cnt", i), bus.stall_cnt, tv[i].ecnt);
    end

    @(negedge clk);
    drive(tv[0]);
    @(negedge clk);
    drive(tv[7]);
    #1;
    chk("pre_rst_stall", {31'd0, bus.stall}, 1);
    chk("pre_rst_cnt", bus.stall_cnt, 6);
    #1 reset = 1'b0;
    #1;
    chk("async_stall", {31'd0, bus.stall}, 0);
    chk("async_rs", {30'd0, bus.fwd_rs_sel}, 0);
    chk("async_rt", {30'd0, bus.fwd_rt_sel}, 0);
    chk("async_cnt", bus.stall_cnt, 0);
    @(negedge clk);
    drive(nop(0));
    reset = 1'b1;
    m_reset();

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      x.a1  = $urandom_range(0, 3);
      x.a2  = $urandom_range(0, 3);
      x.a3  = $urandom_range(0, 3);
      x.we  = ($urandom_range(0, 9) < 7);
      x.tn  = $urandom_range(0, 3);
      x.urs = $urandom_range(0, 1);
      x.urt = $urandom_range(0, 1);
      x.trs = $urandom_range(0, 3);
      x.trt = $urandom_range(0, 3);
      x.fl  = ($urandom_range(0, 9) == 0);
      x.en  = ($urandom_range(0, 9) != 0);
      drive(x);
      #1;
      m_eval(x, st, rs, rt);
      chk("rnd_stall", {31'd0, bus.stall}, {31'd0, st});
      chk("rnd_rs", {30'd0, bus.fwd_rs_sel}, rs);
      chk("rnd_rt", {30'd0, bus.fwd_rt_sel}, rt);
      chk("rnd_cnt", bus.stall_cnt, mcnt);
      m_step(x);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised stall/forward controller for the pipelined MIPS core; the successor to the per-instruction address/timing decoder.
- Takes the decoded A1/A2/A3, Tuse and Tnew of the instruction in D.
- Keeps a shift-register scoreboard of in-flight writers, stage E through the last tracked stage.
- Each cycle it produces the D-stage stall request, D-stage forward selects for rs/rt, and a saturating stall-cycle counter.

Parameters:
DEPTH, 3, number of tracked stages after D (entry 0 = E, entry DEPTH-1 = W)
TW, 2, width of Tnew/Tuse fields
AW, 5, register address width
SW, 2, forward-select width; must satisfy 2^SW > DEPTH

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
en  input  1  pipeline advance enable; 0 freezes the scoreboard (external busy)
a1_d  input  AW  rs address of instruction in D
a2_d  input  AW  rt address of instruction in D
a3_d  input  AW  destination address of instruction in D
we_d  input  1  instruction in D writes a register
tnew_d  input  TW  cycles after entering E until its result is forwardable
use_rs_d  input  1  instruction in D reads rs
use_rt_d  input  1  instruction in D reads rt
tuse_rs_d  input  TW  cycles after D until rs is needed
tuse_rt_d  input  TW  cycles after D until rt is needed
flush_e  input  1  kill the instruction entering E this cycle
stall  output  1  hold PC and D, insert bubble into E
fwd_rs_sel  output  SW  0 = regfile, k = forward from entry k-1
fwd_rt_sel  output  SW  same encoding, for rt
stall_cnt  output  32  total stall cycles since reset

Behaviour:
- Scoreboard entry i holds {v, a3, tnew}.
- Reset (reset=0, asynchronous): all v=0, a3=0, tnew=0, stall_cnt=0. Outputs therefore read stall=0, fwd=0 as soon as reset asserts.
- Match rule: entry i matches rs iff use_rs_d & v_i & a3_i!=0 & a3_i==a1_d. The same rule applies to rt with use_rt_d/a2_d.
- Register 0 never matches.
- Youngest match (lowest i) is the only one considered per operand.
- Stall (combinational from state and D inputs):
  - stall = (youngest rs match has tnew > tuse_rs_d) | (youngest rt match has tnew > tuse_rt_d).
  - No match means no contribution.
- Forward select:
  - fwd_rs_sel = i+1 if the youngest rs match exists with tnew==0, else 0.
  - If the youngest match is not yet ready, select 0; an older ready match is never used.
  - fwd_rt_sel follows the same rule.
- Update on rising clk when en=1:
  - entry0 <= (stall | flush_e | ~we_d) ? {0,0,0} : {1, a3_d, tnew_d}.
  - entry i <= entry i-1 with tnew decremented, saturating at 0, for i = 1..DEPTH-1.
  - The last entry is discarded.
- en=0: all entries hold. stall and fwd are still computed from held state. stall_cnt does not count.
- stall_cnt increments by 1 on each clk with en=1 & stall=1, and saturates at 32'hFFFFFFFF.
- Simultaneous stall and flush_e: bubble inserted, once.
- Reset mid-stall: scoreboard cleared immediately and stall drops the same cycle.
- Latency: scoreboard state is one cycle behind D. stall and fwd outputs are zero-latency from D inputs.

Test Plan:
- lw $8 (tnew_d=2, we_d=1), then addu $9,$8,$0 (use_rs=1, tuse_rs=1) -> cycle 1: stall=1, stall_cnt becomes 1. Cycle 2: stall=0, fwd_rs_sel=0 (entry1 tnew=1).
- lw $8 followed by beq $8,$8 (tuse=0 both) -> stall=1 for 2 cycles; third cycle stall=0, fwd_rs_sel=fwd_rt_sel=3 (W, tnew=0); stall_cnt=2.
- ori $5 (tnew_d=1), then sw using $5 as rt with tuse_rt=2 -> stall=0 throughout; next cycle entry0 tnew=1 > no stall since 1<=2; fwd_rt_sel=0.
- Writer to $0 (a3_d=0, tnew_d=2), then reader of $0 with tuse=0 -> stall=0, fwd_rs_sel=0.
- Two writers to $7: lui $7 (tnew=0), then lw $7 (tnew=2), then reader tuse=1 -> stall=1; fwd_rs_sel=0, never 2.
- en=0 held 3 cycles during a pending stall -> entries frozen, stall stays 1, stall_cnt unchanged.
- Assert reset low mid-sequence -> stall=0, fwd=0 and stall_cnt=0 asynchronously, before the next clk edge.
